// File: rtl/tdp_ram_pkg.sv
// tdp_ram_pkg: shared types and constants for tdp_ram (read latency follows TDP_RAM_OUT_REG_EN)
package tdp_ram_pkg;
  typedef enum logic {INIT, READY} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
  localparam port_t COLL_PRIO = PORT_A;
`ifdef TDP_RAM_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
endpackage

// File: rtl/tdp_ram_rdpipe.sv
// tdp_ram_rdpipe: per-port read data/valid pipeline, extra stage when TDP_RAM_OUT_REG_EN is defined
module tdp_ram_rdpipe #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic              v1;
  logic [DATA_W-1:0] d1;
  // first stage: capture array data on an accepted read, hold otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) d1 <= in_data;
    end
`ifdef TDP_RAM_OUT_REG_EN
  logic              v2;
  logic [DATA_W-1:0] d2;
  // optional output stage, same hold behaviour, flushed by rst
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2 <= 1'b0;
      d2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) d2 <= d1;
    end
  assign out_valid = v2;
  assign out_data  = d2;
`else
  assign out_valid = v1;
  assign out_data  = d1;
`endif
endmodule

// File: rtl/tdp_ram.sv
// tdp_ram: true dual-port RAM with post-reset clear sweep and write collision flag (TDP_RAM_OUT_REG_EN adds an output stage)
module tdp_ram
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              init_done,
  output logic              collision
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic              rdy, a_wr, b_wr, a_rd, b_rd, clash, a_keep, b_keep;
  assign rdy       = state == READY;
  assign init_done = rdy;
  assign a_wr      = rdy & a_en & a_we;
  assign b_wr      = rdy & b_en & b_we;
  assign a_rd      = rdy & a_en & ~a_we;
  assign b_rd      = rdy & b_en & ~b_we;
  assign clash     = a_wr & b_wr & (a_addr == b_addr);
  assign a_keep    = a_wr & ~(clash & COLL_PRIO == PORT_B);
  assign b_keep    = b_wr & ~(clash & COLL_PRIO == PORT_A);
  // state and clear pointer registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  // sweep walks every word once, then parks in READY
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    if (state == INIT) begin
      ptr_nx   = ptr + 1'b1;
      state_nx = (ptr == {ADDR_W{1'b1}}) ? READY : INIT;
    end
  end
  // array writes: sweep zeroes during INIT, port writes in READY with A winning a clash
  always_ff @(posedge clk)
    if (state == INIT) mem[ptr] <= '0;
    else begin
      if (a_keep) mem[a_addr] <= a_wdata;
      if (b_keep) mem[b_addr] <= b_wdata;
    end
  // collision flag registered one cycle after the clashing writes
  always_ff @(posedge clk or posedge rst)
    if (rst) collision <= 1'b0;
    else     collision <= clash;
  tdp_ram_rdpipe #(.DATA_W(DATA_W)) u_pipe_a (
    .clk(clk), .rst(rst), .in_valid(a_rd), .in_data(mem[a_addr]),
    .out_valid(a_rvalid), .out_data(a_rdata)
  );
  tdp_ram_rdpipe #(.DATA_W(DATA_W)) u_pipe_b (
    .clk(clk), .rst(rst), .in_valid(b_rd), .in_data(mem[b_addr]),
    .out_valid(b_rvalid), .out_data(b_rdata)
  );
endmodule

// File: tb/tb_tdp_ram.sv
// tb_tdp_ram: directed self-checking bench for tdp_ram
module tb_tdp_ram;
  import tdp_ram_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
  logic [4:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic [7:0] a_rdata, b_rdata;
  logic       a_rvalid, b_rvalid, init_done, collision;
  int         errors = 0, checks = 0;
  tdp_ram #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .init_done(init_done), .collision(collision)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0;
  endtask
  task automatic wr_a(input logic [4:0] ad, input logic [7:0] d);
    a_en = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d;
    tick();
    idle();
  endtask
  task automatic rd(input logic pb, input logic [4:0] ad, input logic [7:0] ex, input string tag);
    if (pb) begin b_en = 1'b1; b_we = 1'b0; b_addr = ad; end
    else begin a_en = 1'b1; a_we = 1'b0; a_addr = ad; end
    tick();
    idle();
    repeat (RD_LAT - 1) tick();
    chk({tag, "_v"}, pb ? b_rvalid : a_rvalid, 1'b1);
    chk({tag, "_d"}, pb ? b_rdata : a_rdata, ex);
  endtask
  task automatic sweep(input string tag, input logic busy);
    int low = 0, rv = 0;
    rst = 1'b0;
    if (busy) begin
      a_en = 1'b1; a_we = 1'b1; a_addr = 5'd0; a_wdata = 8'hAA;
      b_en = 1'b1; b_we = 1'b0; b_addr = 5'd0;
    end
    for (int i = 0; i < 32; i++) begin
      if (!init_done) low++;
      if (a_rvalid || b_rvalid) rv++;
      tick();
    end
    idle();
    chk({tag, "_init_low"}, low, 32);
    chk({tag, "_no_rvalid"}, rv, 0);
    chk({tag, "_init_done"}, init_done, 1'b1);
  endtask
  initial begin
    #1;
    chk("rst_a_rdata", a_rdata, 8'h00);
    chk("rst_b_rdata", b_rdata, 8'h00);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_collision", collision, 1'b0);
    tick(); tick();
    sweep("sw0", 1'b0);
    for (int i = 0; i < 32; i++) wr_a(5'(i), 8'hFF);
    rd(1'b1, 5'd31, 8'hFF, "preload");
    rst = 1'b1;
    tick();
    sweep("sw1", 1'b1);
    for (int i = 0; i < 32; i++) rd(1'b1, 5'(i), 8'h00, $sformatf("clr%0d", i));
    rd(1'b0, 5'd0, 8'h00, "init_req_ignored");
    wr_a(5'd3, 8'h5A);
    rd(1'b1, 5'd3, 8'h5A, "basic");
    tick();
    chk("basic_pulse_end", b_rvalid, 1'b0);
    chk("basic_hold", b_rdata, 8'h5A);
    a_en = 1'b1; a_we = 1'b1; a_addr = 5'd7; a_wdata = 8'h11;
    b_en = 1'b1; b_we = 1'b1; b_addr = 5'd7; b_wdata = 8'h22;
    tick();
    idle();
    chk("coll_pulse", collision, 1'b1);
    tick();
    chk("coll_end", collision, 1'b0);
    rd(1'b0, 5'd7, 8'h11, "coll_a_wins");
    a_en = 1'b1; a_we = 1'b1; a_addr = 5'd8; a_wdata = 8'h01;
    b_en = 1'b1; b_we = 1'b1; b_addr = 5'd9; b_wdata = 8'h33;
    tick();
    idle();
    chk("no_coll_diff_addr", collision, 1'b0);
    a_en = 1'b1; a_we = 1'b1; a_addr = 5'd9; a_wdata = 8'h44;
    b_en = 1'b1; b_we = 1'b0; b_addr = 5'd9;
    tick();
    idle();
    repeat (RD_LAT - 1) tick();
    chk("rf_old_v", b_rvalid, 1'b1);
    chk("rf_old_d", b_rdata, 8'h33);
    rd(1'b1, 5'd9, 8'h44, "rf_new");
    rd(1'b0, 5'd8, 8'h01, "diff_addr_b");
    a_en = 1'b1; a_we = 1'b0; a_addr = 5'd3;
    b_en = 1'b1; b_we = 1'b0; b_addr = 5'd3;
    tick();
    idle();
    chk("rr_no_coll", collision, 1'b0);
    repeat (RD_LAT - 1) tick();
    chk("rr_a", a_rdata, 8'h5A);
    chk("rr_b", b_rdata, 8'h5A);
    a_en = 1'b1; a_we = 1'b0; a_addr = 5'd3;
    repeat (4) tick();
    chk("stream_v", a_rvalid, 1'b1);
    chk("stream_d", a_rdata, 8'h5A);
    rst = 1'b1;
    #1;
    chk("mid_rst_v", a_rvalid, 1'b0);
    chk("mid_rst_d", a_rdata, 8'h00);
    chk("mid_rst_init", init_done, 1'b0);
    tick(); tick();
    idle();
    sweep("sw2", 1'b0);
    rd(1'b0, 5'd3, 8'h00, "after_rst_clear");
    rd(1'b1, 5'd7, 8'h00, "after_rst_clear7");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
